// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    localparam int unsigned WAIT_W           = 4;
    localparam int unsigned MAX_WAIT_DEFAULT = 4;

    // Which source owns the write port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_MDU
    } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Tracks registers with an outstanding MDU result and flags decode-stage hazards on them.
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  reg_addr_t   set_addr,
    input  logic        clr_en,
    input  reg_addr_t   clr_addr,
    input  reg_addr_t   rs_a,
    input  reg_addr_t   rt_a,
    input  reg_addr_t   rd_a,
    output logic [31:0] pending,
    output logic        raw_stall
);

    logic [31:0] pending_q, pending_d;

    // Next bitmap: clear on MDU handshake, then set on issue so a same-cycle set wins
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Bitmap register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Hazard compare on the registered bitmap; bit 0 is never set so r0 never stalls
    always_comb begin
        raw_stall = pending_q[rs_a] | pending_q[rt_a] | pending_q[rd_a];
    end

    assign pending = pending_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between writeback and the MDU, with a bounded
// starvation wait for MDU results and a scoreboard of outstanding MDU destinations.
module rf_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  reg_addr_t   wb_a3,
    input  word_t       wb_wd,
    input  logic        mdu_valid,
    input  reg_addr_t   mdu_a3,
    input  word_t       mdu_wd,
    output logic        mdu_ready,
    input  logic        mdu_issue,
    input  reg_addr_t   mdu_rd,
    input  reg_addr_t   rs_a,
    input  reg_addr_t   rt_a,
    input  reg_addr_t   rd_a,
    output logic        raw_stall,
    output logic        wb_stall,
    output logic        we3,
    output reg_addr_t   A3,
    output word_t       WD3,
    output logic [31:0] pending
);

    localparam logic [WAIT_W-1:0] MaxWaitC = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              wb_req;
    logic              force_mdu;
    grant_e            grant;

    assign wb_req    = wb_we && (wb_a3 != '0);
    assign force_mdu = mdu_valid && (wait_cnt_q == MaxWaitC);

    // Arbitration; reset drops any grant immediately so an in-flight forced write never commits
    always_comb begin
        grant     = GNT_NONE;
        mdu_ready = 1'b0;
        wb_stall  = 1'b0;
        if (!reset) begin
            if (force_mdu) begin
                grant     = GNT_MDU;
                mdu_ready = 1'b1;
                wb_stall  = 1'b1;
            end else if (wb_req) begin
                grant = GNT_WB;
            end else if (mdu_valid) begin
                grant     = GNT_MDU;
                mdu_ready = 1'b1;
            end
        end
    end

    // Write-port mux; an MDU result to r0 handshakes but never writes
    always_comb begin
        we3 = 1'b0;
        A3  = '0;
        WD3 = '0;
        unique case (grant)
            GNT_WB: begin
                we3 = 1'b1;
                A3  = wb_a3;
                WD3 = wb_wd;
            end
            GNT_MDU: begin
                if (mdu_a3 != '0) begin
                    we3 = 1'b1;
                    A3  = mdu_a3;
                    WD3 = mdu_wd;
                end
            end
            default: ;
        endcase
    end

    // Count consecutive refused cycles of a valid MDU result
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!mdu_valid || mdu_ready) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MaxWaitC) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_en    (mdu_issue && (mdu_rd != '0)),
        .set_addr  (mdu_rd),
        .clr_en    (mdu_valid && mdu_ready),
        .clr_addr  (mdu_a3),
        .rs_a      (rs_a),
        .rt_a      (rt_a),
        .rd_a      (rd_a),
        .pending   (pending),
        .raw_stall (raw_stall)
    );

endmodule
